// File: rtl/queue_pkg.sv
// Shared constants and sizing helper for the cell/UART message queue.
package queue_pkg;

  // 2*(ADDR_WIDTH+1)+4 with ADDR_WIDTH=4
  localparam int DEFAULT_WIDTH = 14;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/queue_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module queue_mem
  import queue_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 4,
  localparam int PTR_W = clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: storage is not reset; stale entries are never visible because the
  // read side is masked by the occupancy count, which is reset.
  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/queue.sv
// Synchronous message FIFO with level-request/one-cycle-ack write handshake and
// edge-qualified pop. Optional status ports (level/full/overflow) under QUEUE_STATUS_EN.
module queue
  import queue_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [WIDTH-1:0]           write,
  input  logic                       write_en,
  output logic                       write_ack,
  output logic [WIDTH-1:0]           read,
  output logic                       read_en,
  input  logic                       read_ack
`ifdef QUEUE_STATUS_EN
  ,
  output logic [clog2(DEPTH+1)-1:0]  level,
  output logic                       full,
  output logic                       overflow
`endif
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             write_ack_q, write_ack_d;
  logic             ack_q, ack_d;
  logic             push, pop, is_full;
  logic [WIDTH-1:0] head;

  assign is_full = (count_q == FULL_CNT);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    push        = write_en && !write_ack_q && !is_full;
    pop         = read_ack && !ack_q && (count_q != '0);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    write_ack_d = push;
    ack_d       = read_ack;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    // Full blocks push using the pre-edge count, so push+pop when full is pop-only.
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      write_ack_q <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      write_ack_q <= write_ack_d;
      ack_q       <= ack_d;
    end
  end

  queue_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clock   (clock),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (write),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  assign write_ack = write_ack_q;
  assign read_en   = (count_q != '0);
  assign read      = read_en ? head : '0;

`ifdef QUEUE_STATUS_EN
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q | (write_en && !write_ack_q && is_full);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) overflow_q <= 1'b0;
    else          overflow_q <= overflow_d;
  end

  assign level    = count_q;
  assign full     = is_full;
  assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_queue.sv
// Directed self-checking bench for queue (WIDTH=14, DEPTH=4); status ports checked under QUEUE_STATUS_EN.
module tb_queue;

  localparam int WIDTH = 14;
  localparam int DEPTH = 4;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] write;
  logic             write_en;
  logic             write_ack;
  logic [WIDTH-1:0] read;
  logic             read_en;
  logic             read_ack;
`ifdef QUEUE_STATUS_EN
  logic [2:0]       level;
  logic             full;
  logic             overflow;
`endif

  int n_cmp = 0;
  int n_err = 0;

  queue #(WIDTH, DEPTH) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .write     (write),
    .write_en  (write_en),
    .write_ack (write_ack),
    .read      (read),
    .read_en   (read_en),
    .read_ack  (read_ack)
`ifdef QUEUE_STATUS_EN
    ,
    .level     (level),
    .full      (full),
    .overflow  (overflow)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle, so samples and drives sit between edges.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] val);
    bit seen;
    seen     = 1'b0;
    write    = val;
    write_en = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = write_ack;
    end
    write_en = 1'b0;
    if (!seen) check("push_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic pop(output logic [WIDTH-1:0] val);
    val      = read;
    read_ack = 1'b1;
    tick();
    read_ack = 1'b0;
    tick();
  endtask

  logic [WIDTH-1:0] got;
  int               acks;
  bit               wide_pulse;
  logic             prev_ack;

  initial begin
    reset_n  = 1'b0;
    write    = '0;
    write_en = 1'b0;
    read_ack = 1'b0;

    // 1. reset / idle
    repeat (2) tick();
    check("rst_read_en", read_en, 0);
    check("rst_read", read, 0);
    check("rst_write_ack", write_ack, 0);
`ifdef QUEUE_STATUS_EN
    check("rst_level", level, 0);
`endif
    reset_n = 1'b1;
    tick();

    // 2. single push
    write    = 14'h2A5;
    write_en = 1'b1;
    tick();
    check("single_ack_hi", write_ack, 1);
    check("single_read_en", read_en, 1);
    check("single_read", read, 14'h2A5);
    write_en = 1'b0;
    tick();
    check("single_ack_lo", write_ack, 0);
    read_ack = 1'b1;
    tick();
    read_ack = 1'b0;
    check("single_pop_empty", read_en, 0);
    tick();

    // 3. fill and overflow
    for (int i = 1; i <= 4; i++) push(WIDTH'(i));
    write    = 14'd5;
    write_en = 1'b1;
    tick();
    check("full_no_ack", write_ack, 0);
    check("full_head", read, 1);
    tick();
    check("full_no_ack2", write_ack, 0);
`ifdef QUEUE_STATUS_EN
    check("full_flag", full, 1);
    check("overflow_set", overflow, 1);
`endif
    read_ack = 1'b1;
    tick();
    check("full_pop_blocks_push", write_ack, 0);
    read_ack = 1'b0;
    tick();
    check("after_pop_ack", write_ack, 1);
    check("after_pop_head", read, 2);
    write_en = 1'b0;
    tick();
    for (int i = 2; i <= 5; i++) begin
      pop(got);
      check("drain_order", got, i);
    end
    check("drain_empty", read_en, 0);
    read_ack = 1'b1;
    tick();
    read_ack = 1'b0;
    tick();
    check("empty_pop_read_en", read_en, 0);
    check("empty_pop_read", read, 0);
`ifdef QUEUE_STATUS_EN
    check("overflow_sticky", overflow, 1);
    check("empty_level", level, 0);
`endif

    // 4. order across pointer wrap
    push(14'h10);
    for (int i = 1; i < 10; i++) begin
      push(WIDTH'(14'h10 + i));
      pop(got);
      check("wrap_order", got, 14'h10 + i - 1);
    end
    pop(got);
    check("wrap_last", got, 14'h19);
    check("wrap_empty", read_en, 0);

    // 5a. held read_ack pops once
    push(14'h31);
    push(14'h32);
    push(14'h33);
    read_ack = 1'b1;
    repeat (5) tick();
    read_ack = 1'b0;
    tick();
    check("held_rd_head", read, 14'h32);
`ifdef QUEUE_STATUS_EN
    check("held_rd_level", level, 2);
`endif
    pop(got);
    check("held_rd_pop1", got, 14'h32);
    pop(got);
    check("held_rd_pop2", got, 14'h33);
    check("held_rd_empty", read_en, 0);

    // 5b. held write_en: one push per two cycles
    acks       = 0;
    wide_pulse = 1'b0;
    prev_ack   = 1'b0;
    write      = 14'h55;
    write_en   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (write_ack) acks++;
      if (write_ack && prev_ack) wide_pulse = 1'b1;
      prev_ack = write_ack;
    end
    write_en = 1'b0;
    tick();
    check("held_wr_acks", acks, 3);
    check("held_wr_pulse_width", wide_pulse, 0);
`ifdef QUEUE_STATUS_EN
    check("held_wr_level", level, 3);
`endif
    for (int i = 0; i < 3; i++) begin
      pop(got);
      check("held_wr_data", got, 14'h55);
    end
    check("held_wr_empty", read_en, 0);

    // 6. reset mid-run
    push(14'h61);
    push(14'h62);
    check("pre_rst_read_en", read_en, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_read_en", read_en, 0);
    check("async_rst_read", read, 0);
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_read_en", read_en, 0);
    check("post_rst_ack", write_ack, 0);
    push(14'h77);
    check("post_rst_push", read, 14'h77);
    pop(got);
    check("post_rst_pop", got, 14'h77);
    check("post_rst_empty", read_en, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
